rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 4:1 mux datapath.
- Four requesters compete for one downstream output channel. The block picks one, drives the mux select, and locks the grant for a packet or burst.
- Forwards the selected requester's data through a valid/ready handshake to the downstream consumer.
- Sits between the requesters and the shared mux/output path; replaces ad-hoc testbench-driven select sequencing.

---
 rtl/rr_mux_arbiter_pkg.sv | 21 ++
 rtl/rr_mux_arbiter_if.sv | 32 +++
 rtl/rr_mux_arbiter_rr_pick4.sv | 32 +++
 rtl/rr_mux_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
//   NUM_REQ     number of requesters sharing the output channel
//   SEL_W       width of the mux select / round-robin pointer
//   state_e     arbiter FSM state encoding
//   onehot_sel  select index -> one-hot grant vector
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
        onehot_sel      = '0;
        onehot_sel[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/downstream bundle for rr_mux_arbiter.
//   req, last, data_in, out_ready   driven by the requester/consumer side
//   grant, sel, out_valid, out_data,
//   out_last, busy                  driven by the arbiter
// master: requester/consumer side; slave: arbiter side.
interface rr_mux_arbiter_if #(
    parameter int DATA_W = 8
);
    import rr_mux_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        last;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic                      out_ready;
    logic [NUM_REQ-1:0]        grant;
    logic [SEL_W-1:0]          sel;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic                      busy;

    modport master (
        output req, last, data_in, out_ready,
        input  grant, sel, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  req, last, data_in, out_ready,
        output grant, sel, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/rr_mux_arbiter_rr_pick4.sv
// Combinational rotate-priority encoder for four requesters.
//   req     request vector
//   ptr     requester with highest priority this round
//   winner  first set bit of req searching ptr, ptr+1, ... (mod 4)
//   any     at least one request present
module rr_pick4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    // Scan from the lowest-priority offset up so the last hit, i.e. the
    // one closest to ptr, is the one that sticks.
    always_comb begin
        winner = ptr;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 mux datapath.
// Picks one of four requesters, locks the grant for a packet (or up to
// MAX_HOLD beats), and forwards that lane through valid/ready.
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      rr_mux_arbiter_if slave modport (requests, lanes, grant, output beat)
// Parameters: DATA_W lane width; MAX_HOLD beats per grant before forced
// release (1..256).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no grant held; arbitrate among req starting at ptr
// ST_LOCKED | grant held for sel; forward lane sel until release
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    rr_mux_arbiter_if.slave  bus
);

    // Counter only needs to reach MAX_HOLD-1: release happens on that beat.
    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [SEL_W-1:0]   pick_winner;
    logic               pick_any;
    logic               locked;
    logic               req_sel;
    logic               last_sel;
    logic               xfer;
    logic               release_c;
    logic [DATA_W-1:0]  lane_sel;

    rr_pick4 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_q == SEL_W'(i)) begin
                lane_sel = bus.data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign locked   = (state_q == ST_LOCKED);
    assign req_sel  = bus.req[sel_q];
    assign last_sel = bus.last[sel_q];
    assign xfer     = locked && req_sel && bus.out_ready;

    // Dropping req[sel] releases even with out_ready high: no beat is valid then.
    assign release_c = !req_sel || (xfer && (last_sel || (cnt_q == CNT_LAST)));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_LOCKED;
                    grant_d = onehot_sel(pick_winner);
                    sel_d   = pick_winner;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (release_c) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = locked;
    assign bus.out_valid = locked && req_sel;
    assign bus.out_last  = locked && last_sel;
    assign bus.out_data  = locked ? lane_sel : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
    import rr_mux_arbiter_pkg::*;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    rr_mux_arbiter_if #(.DATA_W(DATA_W)) bus ();

    rr_mux_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int xfer_seen = 0;

    // Reference model: who owns the channel, rotation start, beats this grant.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_cnt;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic        rdy;
        logic [31:0] din;
        logic [3:0]  eg;
        logic [1:0]  es;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        eb;
    } vec_t;

    vec_t tbl[11];

    task automatic drive(input logic [3:0] r, input logic [3:0] l,
                         input logic [31:0] d, input logic rdy);
        bus.req       = r;
        bus.last      = l;
        bus.data_in   = d;
        bus.out_ready = rdy;
    endtask

    task automatic check_out(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input logic ev, input logic [7:0] ed, input logic el, input logic eb);
        bit bad;
        bad = 1'b0;
        n_vec++;
        if (bus.grant !== eg) begin
            $display("FAIL %s grant: got %b want %b", name, bus.grant, eg); bad = 1'b1;
        end
        if (bus.sel !== es) begin
            $display("FAIL %s sel: got %0d want %0d", name, bus.sel, es); bad = 1'b1;
        end
        if (bus.out_valid !== ev) begin
            $display("FAIL %s out_valid: got %b want %b", name, bus.out_valid, ev); bad = 1'b1;
        end
        if (bus.out_data !== ed) begin
            $display("FAIL %s out_data: got %h want %h", name, bus.out_data, ed); bad = 1'b1;
        end
        if (bus.out_last !== el) begin
            $display("FAIL %s out_last: got %b want %b", name, bus.out_last, el); bad = 1'b1;
        end
        if (bus.busy !== eb) begin
            $display("FAIL %s busy: got %b want %b", name, bus.busy, eb); bad = 1'b1;
        end
        if (bad) n_err++;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            $display("FAIL %s: got %0d want %0d", name, got, want);
            n_err++;
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_cnt    = 0;
    endtask

    task automatic check_model(input string name);
        logic [3:0] eg;
        logic [7:0] ed;
        eg = m_locked ? 4'(1 << m_owner) : 4'b0000;
        ed = m_locked ? bus.data_in[m_owner*8 +: 8] : 8'h00;
        check_out(name, eg, 2'(m_owner), m_locked && bus.req[m_owner], ed,
                  m_locked && bus.last[m_owner], m_locked);
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        bit found;
        bit v;
        bit x;
        found = 1'b0;
        if (!m_locked) begin
            if (r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (!found && r[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        found   = 1'b1;
                    end
                end
                m_locked = 1'b1;
                m_cnt    = 0;
            end
        end else begin
            v = r[m_owner];
            x = v && rdy;
            if (!v || (x && l[m_owner]) || (x && m_cnt == MAX_HOLD - 1)) begin
                m_locked = 1'b0;
                m_cnt    = 0;
                m_ptr    = (m_owner + 1) % 4;
            end else if (x) begin
                m_cnt++;
            end
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model at posedge.
    task automatic run_cycle(input string name, input logic [3:0] r, input logic [3:0] l,
                             input logic [31:0] d, input logic rdy);
        @(negedge clock);
        drive(r, l, d, rdy);
        #1;
        check_model(name);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) xfer_seen++;
        @(posedge clock);
        model_step(r, l, rdy);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        drive(4'b0, 4'b0, 32'h0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        xfer_seen = 0;
    endtask

    int obs[10];
    int exp_rr[10];

    initial begin
        drive(4'b0, 4'b0, 32'h0, 1'b0);
        model_reset();

        //            req      last     rdy   din            grant    sel   v     data   l     busy
        tbl[0]  = '{4'b0100, 4'b0000, 1'b1, 32'h00A0_0000, 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 32'h00A0_0000, 4'b0100, 2'd2, 1'b1, 8'hA0, 1'b0, 1'b1};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 32'h00A1_0000, 4'b0100, 2'd2, 1'b1, 8'hA1, 1'b0, 1'b1};
        tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 32'h00A2_0000, 4'b0100, 2'd2, 1'b1, 8'hA2, 1'b1, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{4'b1001, 4'b0000, 1'b1, 32'h3300_0010, 4'b0000, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{4'b1001, 4'b0000, 1'b0, 32'h3300_0010, 4'b1000, 2'd3, 1'b1, 8'h33, 1'b0, 1'b1};
        tbl[7]  = '{4'b0001, 4'b0000, 1'b1, 32'h3300_0010, 4'b1000, 2'd3, 1'b0, 8'h33, 1'b0, 1'b1};
        tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 32'h3300_0010, 4'b0000, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0001, 1'b1, 32'h3300_0010, 4'b0001, 2'd0, 1'b1, 8'h10, 1'b1, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0};

        exp_rr = '{1, 0, 2, 0, 4, 0, 8, 0, 1, 0};

        // Reset state, sampled while reset is still asserted.
        #2;
        check_out("reset", 4'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Single requester packet, abandon, ptr rotation.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            drive(tbl[i].req, tbl[i].last, tbl[i].din, tbl[i].rdy);
            #1;
            check_out($sformatf("tbl%0d", i), tbl[i].eg, tbl[i].es, tbl[i].ev,
                      tbl[i].ed, tbl[i].el, tbl[i].eb);
            @(posedge clock);
        end

        // Round robin with all requesters held, single-beat packets.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            run_cycle("rr", 4'b1111, 4'b1111, 32'h4433_2211, 1'b1);
            obs[c] = int'(bus.grant);
        end
        for (int c = 0; c < 10; c++) check_val($sformatf("rr_grant%0d", c), obs[c], exp_rr[c]);

        // Backpressure on requester 1.
        do_reset();
        run_cycle("bp", 4'b0010, 4'b0000, 32'h0000_5500, 1'b0);
        run_cycle("bp", 4'b0010, 4'b0000, 32'h0000_5500, 1'b0);
        run_cycle("bp", 4'b0010, 4'b0000, 32'h0000_5500, 1'b1);
        run_cycle("bp", 4'b0010, 4'b0010, 32'h0000_6600, 1'b0);
        run_cycle("bp", 4'b0010, 4'b0010, 32'h0000_6600, 1'b1);
        check_val("bp_xfers", xfer_seen, 2);
        check_val("bp_release", int'(bus.grant), 0);

        // Forced release after MAX_HOLD beats, requester 0 waiting.
        do_reset();
        run_cycle("fr", 4'b1000, 4'b0000, 32'hC000_0000, 1'b1);
        for (int b = 0; b < 4; b++) begin
            run_cycle("fr", 4'b1001, 4'b0000, 32'hC000_0000 | 32'(b << 24), 1'b1);
        end
        check_val("fr_xfers", xfer_seen, 4);
        check_val("fr_release", int'(bus.grant), 0);
        run_cycle("fr", 4'b1001, 4'b0000, 32'h0, 1'b1);
        check_val("fr_next_grant", int'(bus.grant), 1);

        // Abandon: requester 2 drops req mid-packet, requester 3 pending.
        do_reset();
        run_cycle("ab", 4'b0100, 4'b0000, 32'h0077_0000, 1'b1);
        run_cycle("ab", 4'b1100, 4'b0000, 32'h0077_0000, 1'b1);
        run_cycle("ab", 4'b1000, 4'b0000, 32'h0077_0000, 1'b1);
        check_val("ab_release", int'(bus.grant), 0);
        run_cycle("ab", 4'b1000, 4'b0000, 32'h0077_0000, 1'b1);
        check_val("ab_next_grant", int'(bus.grant), 8);

        // Async reset mid-LOCKED, with ptr moved away from 0 beforehand.
        do_reset();
        run_cycle("ar", 4'b0010, 4'b0010, 32'h0, 1'b1);
        run_cycle("ar", 4'b0010, 4'b0010, 32'h0, 1'b1);
        run_cycle("ar", 4'b1000, 4'b0000, 32'h0, 1'b0);
        run_cycle("ar", 4'b1000, 4'b0000, 32'h0, 1'b0);
        check_val("ar_locked", int'(bus.grant), 8);
        #1;
        reset_n = 1'b0;
        #1;
        check_out("ar_async", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(4'b0, 4'b0, 32'h0, 1'b0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        run_cycle("ar", 4'b1010, 4'b0000, 32'h0, 1'b0);
        check_val("ar_first_grant", int'(bus.grant), 2);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] r;
            logic [3:0] l;
            r = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            run_cycle("rnd", r, l, $urandom, ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
